// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one-word reads to a synchronous-read
// instruction memory and buffers returned instructions with their PCs for decode.
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            halt_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o,
    input  logic            ready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = AW + 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            kill_q, kill_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic            pop_s;
    logic            push_s;
    logic            flush_s;
    logic            space_s;
    logic [OW-1:0]   occ_s;
    logic            unused_s;

    assign unused_s = ^redirect_pc_i[1:0];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: BOOT is a single settling cycle before fetching starts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (halt_i) state_d = HALT;
                else        state_d = RUN;
            end
            HALT: begin
                if (!halt_i) state_d = RUN;
                else         state_d = HALT;
            end
            default: state_d = BOOT;
        endcase
    end

    // Outputs: buffer head, and a request gated by occupancy including the
    // response already in flight and the pop happening this cycle.
    always_comb begin
        valid_o    = (count_q != {CW{1'b0}});
        instr_o    = instr_mem_q[rd_ptr_q];
        pc_o       = pc_mem_q[rd_ptr_q];
        mem_addr_o = pc_q;
        pop_s      = valid_o && ready_i;
        occ_s      = OW'(count_q) + OW'(inflight_q) - OW'(pop_s);
        space_s    = (occ_s < OW'(DEPTH));
        mem_req_o  = (state_q == RUN) && !halt_i && !redirect_i && space_s;
    end

    // Datapath next-state: FIFO pointers, fetch PC and in-flight tracking.
    always_comb begin
        flush_s  = redirect_i && (state_q != BOOT);
        push_s   = inflight_q && !kill_q && !flush_s;
        rd_ptr_d = pop_s ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
        if (flush_s) begin
            wr_ptr_d = rd_ptr_d;
            count_d  = {CW{1'b0}};
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
        end
        if (flush_s) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (mem_req_o) begin
            pc_d = pc_q + XLEN'(32'd4);
        end else begin
            pc_d = pc_q;
        end
        req_pc_d   = mem_req_o ? pc_q : req_pc_q;
        inflight_d = mem_req_o;
        kill_d     = flush_s ? inflight_q : 1'b0;
    end

    // Datapath registers and FIFO storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= {XLEN{1'b0}};
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= {XLEN{1'b0}};
                pc_mem_q[i]    <= {XLEN{1'b0}};
            end
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (push_s) begin
                instr_mem_q[wr_ptr_q] <= mem_rdata_i;
                pc_mem_q[wr_ptr_q]    <= req_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed cycle checks plus a randomized run scored
// against the expected sequential instruction stream.
module tb_fetch_ctrl;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        halt_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i = 32'hBAD0_BAD0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    fetch_ctrl #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .halt_i(halt_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .instr_o(instr_o), .pc_o(pc_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    int          pop_count = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tail_pc = 32'd0;
    logic        restart_pend = 1'b0;
    logic [31:0] restart_pc = 32'd0;
    logic        boot_cycle = 1'b1;

    // Memory word n holds n.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous-read memory: answers one cycle after a request.
    logic        m_req;
    logic [31:0] m_addr;
    initial begin
        forever begin
            @(negedge clk_i);
            m_req  = mem_req_o;
            m_addr = mem_addr_o;
            @(posedge clk_i);
            #1;
            mem_rdata_i = m_req ? mem_word(m_addr) : 32'hBAD0_BAD0;
        end
    end

    // Advance to the next cycle; a restart (reset/redirect) issued last cycle
    // takes effect at this edge and replaces the expected stream.
    task automatic next_cycle();
        @(posedge clk_i);
        if (restart_pend) begin
            exp_q.delete();
            tail_pc = restart_pc;
            exp_q.push_back(tail_pc);
            restart_pend = 1'b0;
        end
        while (exp_q.size() < 8) begin
            tail_pc = tail_pc + 32'd4;
            exp_q.push_back(tail_pc);
        end
        #1;
    endtask

    task automatic cycle(input logic r, input logic h, input logic d,
                         input logic [31:0] t, input logic y);
        next_cycle();
        rst_i = r; halt_i = h; redirect_i = d; redirect_pc_i = t; ready_i = y;
        if (r) begin
            restart_pend = 1'b1;
            restart_pc   = RESET_PC;
        end else if (d && !boot_cycle) begin
            restart_pend = 1'b1;
            restart_pc   = {t[31:2], 2'b00};
        end
        boot_cycle = r;
        @(negedge clk_i);
    endtask

    // Scoreboard monitor: pops expected PCs on every handshake, and checks
    // head stability under backpressure and emptiness after a flush.
    logic        mon_pv = 1'b0, mon_pr = 1'b0, mon_pf = 1'b0;
    logic [31:0] mon_ppc = 32'd0, mon_pin = 32'd0, mon_e;
    initial begin
        forever begin
            @(negedge clk_i);
            if (mon_pf) begin
                check("valid_after_flush", 32'(valid_o), 32'd0);
            end else if (mon_pv && !mon_pr) begin
                check("hold_valid", 32'(valid_o), 32'd1);
                check("hold_pc", pc_o, mon_ppc);
                check("hold_instr", instr_o, mon_pin);
            end
            if (mem_req_o) check("addr_align", 32'(mem_addr_o[1:0]), 32'd0);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: popped pc %h with nothing expected", pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_pc", pc_o, mon_e);
                    check("sb_instr", instr_o, mem_word(mon_e));
                end
                pop_count++;
            end
            mon_pv  = valid_o;
            mon_pr  = ready_i;
            mon_pf  = rst_i | redirect_i;
            mon_ppc = pc_o;
            mon_pin = instr_o;
        end
    end

    task automatic startup();
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_addr", mem_addr_o, RESET_PC);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("c1_req", 32'(mem_req_o), 32'd1);
        check("c1_addr", mem_addr_o, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("c2_valid", 32'(valid_o), 32'd0);
        check("c2_addr", mem_addr_o, 32'd4);
        for (int k = 3; k <= 10; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
            check("stream_valid", 32'(valid_o), 32'd1);
            check("stream_pc", pc_o, 32'(4 * (k - 3)));
            check("stream_instr", instr_o, 32'(k - 3));
            check("stream_req", 32'(mem_req_o), 32'd1);
            check("stream_addr", mem_addr_o, 32'(4 * (k - 1)));
        end
    endtask

    logic        r_r, r_h, r_ph, r_d, r_y;
    logic [31:0] r_t;
    int          pops_before;

    initial begin
        // Free-running startup with decode always ready.
        startup();

        // Backpressure from the start.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        check("bp_req0", mem_addr_o, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        check("bp_req1", 32'(mem_req_o), 32'd1);
        check("bp_addr1", mem_addr_o, 32'd4);
        for (int k = 3; k <= 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            check("bp_noreq", 32'(mem_req_o), 32'd0);
            check("bp_valid", 32'(valid_o), 32'd1);
            check("bp_pc", pc_o, 32'd0);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("bp_resume_req", 32'(mem_req_o), 32'd1);
        check("bp_resume_addr", mem_addr_o, 32'd8);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect with a read of 0x8 in flight, then misaligned and wrapping targets.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k <= 3; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("redir_pre_addr", mem_addr_o, 32'd8);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        check("redir_noreq", 32'(mem_req_o), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("redir_valid0", 32'(valid_o), 32'd0);
        check("redir_req", 32'(mem_req_o), 32'd1);
        check("redir_addr", mem_addr_o, 32'h0000_0100);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("redir_addr2", mem_addr_o, 32'h0000_0104);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("redir_head_valid", 32'(valid_o), 32'd1);
        check("redir_head_pc", pc_o, 32'h0000_0100);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("misalign_addr", mem_addr_o, 32'h0000_0200);
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("wrap_addr0", mem_addr_o, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("wrap_req1", 32'(mem_req_o), 32'd1);
        check("wrap_addr1", mem_addr_o, 32'h0000_0000);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Halt with a read in flight, then resume at the next sequential PC.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k <= 4; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 5; k <= 9; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
            check("halt_noreq", 32'(mem_req_o), 32'd0);
            if (k == 6) check("halt_inflight_pc", pc_o, 32'd12);
        end
        check("halt_drained", 32'(valid_o), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("unhalt_noreq", 32'(mem_req_o), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        check("unhalt_req", 32'(mem_req_o), 32'd1);
        check("unhalt_addr", mem_addr_o, 32'd16);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Reset mid-stream with a buffered entry and a read in flight.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k <= 2; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        startup();

        // Randomized traffic scored against the sequential-stream model.
        pops_before = pop_count;
        r_h = 1'b0;
        r_ph = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r_r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) r_h = ~r_h;
            r_y = ($urandom_range(0, 9) < 7);
            r_t = $urandom;
            if ($urandom_range(0, 3) == 0) r_t = 32'hFFFF_FFF0 | (r_t & 32'h0000_000F);
            r_d = 1'b0;
            if (!r_r && !r_h && !r_ph && !boot_cycle && ($urandom_range(0, 19) == 0)) r_d = 1'b1;
            cycle(r_r, r_h, r_d, r_t, r_y);
            r_ph = r_h;
        end
        checks++;
        if (pop_count - pops_before <= 300) begin
            errors++;
            $display("FAIL random_progress: got %0d pops expected more than 300", pop_count - pops_before);
        end

        // Steady state with decode always ready: one instruction per cycle.
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        pops_before = pop_count;
        for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checks++;
        if (pop_count - pops_before < 19) begin
            errors++;
            $display("FAIL throughput: got %0d pops in 20 cycles expected at least 19", pop_count - pops_before);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
